// File: rtl/proc_elem_pkg.sv
// Shared definitions for processing-element variants: weight-buffer FSM
// states and saturation bounds for a signed accumulator of arbitrary width.
package proc_elem_pkg;

  localparam int MAX_ACC_WIDTH = 64;

  typedef enum logic [1:0] {
    W_EMPTY       = 2'd0,
    W_ACTIVE      = 2'd1,
    W_ACTIVE_PEND = 2'd2,
    W_PEND_ONLY   = 2'd3
  } w_state_t;

  // Bounds are returned in a 64-bit container; callers keep the low w bits.
  function automatic logic [MAX_ACC_WIDTH-1:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_ACC_WIDTH-1:0] acc_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Signed adder with overflow detection and optional clamp to the
// representable range (SATURATE=1) or plain two's-complement wrap.
module sat_adder
  import proc_elem_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  localparam logic [ACC_WIDTH-1:0] SUM_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SUM_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

  logic [ACC_WIDTH-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);

  always_comb begin
    sum = raw;
    if (SATURATE && ovf) begin
      // Overflow direction follows the common operand sign.
      sum = a[ACC_WIDTH-1] ? SUM_MIN : SUM_MAX;
    end
  end

endmodule

// File: rtl/proc_elem_db.sv
// Systolic processing element with a double-buffered weight: MAC of the
// left activation against the active weight, accumulated onto the top sum.
module proc_elem_db
  import proc_elem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic                  in_left_valid,
  input  logic [ACC_WIDTH-1:0]  in_top,
  input  logic                  in_top_valid,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic                  w_load,
  input  logic                  w_swap,
  input  logic                  clear_sat,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_right_valid,
  output logic [ACC_WIDTH-1:0]  out_down,
  output logic                  out_down_valid,
  output logic                  w_ready,
  output logic                  shadow_full,
  output logic                  sat_flag
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
    $error("proc_elem_db: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  // state         | meaning
  // W_EMPTY       | no active weight, no shadow weight
  // W_ACTIVE      | active weight valid, shadow empty
  // W_ACTIVE_PEND | active weight valid, shadow holds unpromoted weight
  // W_PEND_ONLY   | shadow holds a weight, nothing active yet
  w_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] active_w;
  logic [DATA_WIDTH-1:0] shadow_w;
  logic                  do_swap;
  logic                  active_nxt;
  logic                  shadow_nxt;

  assign w_ready     = (state == W_ACTIVE) || (state == W_ACTIVE_PEND);
  assign shadow_full = (state == W_ACTIVE_PEND) || (state == W_PEND_ONLY);
  assign do_swap     = w_swap && shadow_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= W_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    active_nxt = w_ready || do_swap;
    // A swap drains the shadow unless a load refills it in the same cycle.
    shadow_nxt = w_load || (shadow_full && !w_swap);
    state_nxt  = W_EMPTY;
    case ({active_nxt, shadow_nxt})
      2'b00:   state_nxt = W_EMPTY;
      2'b10:   state_nxt = W_ACTIVE;
      2'b11:   state_nxt = W_ACTIVE_PEND;
      default: state_nxt = W_PEND_ONLY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_w <= '0;
      shadow_w <= '0;
    end else begin
      if (do_swap) active_w <= shadow_w;
      if (w_load)  shadow_w <= w_in;
    end
  end

  logic signed [2*DATA_WIDTH-1:0] product;
  logic        [ACC_WIDTH-1:0]    product_ext;
  logic        [ACC_WIDTH-1:0]    mac_sum;
  logic                           mac_ovf;
  logic                           mac_en;

  assign product     = $signed(active_w) * $signed(in_left);
  assign product_ext = ACC_WIDTH'(product);
  assign mac_en      = in_top_valid && in_left_valid && w_ready;

  sat_adder #(
    .ACC_WIDTH(ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_adder (
    .a  (in_top),
    .b  (product_ext),
    .sum(mac_sum),
    .ovf(mac_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_right       <= '0;
      out_right_valid <= 1'b0;
      out_down        <= '0;
      out_down_valid  <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      out_right       <= in_left;
      out_right_valid <= in_left_valid;
      out_down_valid  <= in_top_valid;
      if (in_top_valid) begin
        out_down <= mac_en ? mac_sum : in_top;
      end
      if (mac_en && mac_ovf) begin
        sat_flag <= 1'b1;
      end else if (clear_sat) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/proc_elem_db.md
PROC_ELEM_DB -- requirements
Module: proc_elem_db

Interface
REQ-001 DATA_WIDTH, 16, activation/weight width, signed.
REQ-002 ACC_WIDTH, 32, partial-sum width, signed; SHALL be >= 2*DATA_WIDTH (elaboration error otherwise).
REQ-003 SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in_left  input  DATA_WIDTH  activation from left neighbour.
REQ-007 in_left_valid  input  1  in_left qualifier.
REQ-008 in_top  input  ACC_WIDTH  partial sum from upper neighbour.
REQ-009 in_top_valid  input  1  in_top qualifier.
REQ-010 w_in  input  DATA_WIDTH  weight load data.
REQ-011 w_load  input  1  write w_in into shadow weight.
REQ-012 w_swap  input  1  promote shadow weight to active.
REQ-013 clear_sat  input  1  clear sticky saturation flag.
REQ-014 out_right  output  DATA_WIDTH  registered in_left to right neighbour.
REQ-015 out_right_valid  output  1  registered in_left_valid.
REQ-016 out_down  output  ACC_WIDTH  registered partial sum to lower neighbour.
REQ-017 out_down_valid  output  1  out_down qualifier.
REQ-018 w_ready  output  1  1 when active weight holds a loaded value.
REQ-019 shadow_full  output  1  1 when shadow holds an unpromoted weight.
REQ-020 sat_flag  output  1  sticky overflow indicator.

Function
REQ-021 out_right/out_right_valid SHALL equal in_left/in_left_valid delayed exactly 1 cycle, unconditionally.
REQ-022 Weight FSM states: EMPTY (no active, no shadow), ACTIVE (active only), ACTIVE_PEND (active + shadow), PEND_ONLY (shadow only); w_ready = state in {ACTIVE, ACTIVE_PEND}; shadow_full = state in {ACTIVE_PEND, PEND_ONLY}.
REQ-023 w_load SHALL write shadow and set shadow_full next cycle; load while shadow_full overwrites shadow.
REQ-024 w_swap with shadow_full SHALL copy shadow to active and clear shadow_full next cycle; w_swap with shadow empty SHALL be ignored.
REQ-025 w_load and w_swap same cycle: swap promotes pre-cycle shadow, new w_in lands in shadow (shadow_full stays 1); if shadow was empty, only the load takes effect.
REQ-026 Compute in any cycle SHALL use the pre-edge active weight (swap never affects same-cycle MAC).
REQ-027 If in_top_valid=1, in_left_valid=1, w_ready=1: out_down <= in_top + sign_extend(active_w * in_left), out_down_valid <= 1, latency 1 cycle.
REQ-028 If in_top_valid=1 and (in_left_valid=0 or w_ready=0): out_down <= in_top unchanged, out_down_valid <= 1 (bypass).
REQ-029 If in_top_valid=0: out_down_valid <= 0, out_down holds previous value.
REQ-030 Product SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH before addition.
REQ-031 Overflow (operands same sign, sum sign differs): SATURATE=1 clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); SATURATE=0 wraps; both set sat_flag.
REQ-032 sat_flag set and clear_sat same cycle: set wins.
REQ-033 Throughput: one MAC per cycle, no back-pressure.

Reset
REQ-034 reset assertion SHALL immediately zero all outputs, active and shadow weights, sat_flag, and force FSM to EMPTY.
REQ-035 reset mid-stream discards in-flight sums; first valid input after deassertion behaves as after power-up.

Structure
REQ-036 Package proc_elem_pkg SHALL hold the weight FSM state enum and saturation-bound helper constants/functions shared across PE variants.
REQ-037 One sub-module sat_adder (ACC_WIDTH, SATURATE) SHALL implement add, overflow detect, clamp; multiplier remains inline.

Verification
REQ-038 DW=16: load 3, swap, in_left=-4, in_top=100, both valid -> out_down=88, valid next cycle, w_ready=1.
REQ-039 No swap after load: in_left=5, in_top=7 -> out_down=7 (bypass), shadow_full=1, w_ready=0.
REQ-040 Active=2, shadow=9, w_swap with in_left=10,in_top=0 same cycle -> out_down=20; next MAC uses 9.
REQ-041 ACC=32, SATURATE=1: in_top=0x7FFFFFF0, w=1, in_left=0x0100 -> out_down=0x7FFFFFFF, sat_flag=1; SATURATE=0 -> 0x800000F0, sat_flag=1.
REQ-042 Simultaneous overflow and clear_sat -> sat_flag=1; clear_sat alone next cycle -> 0.
REQ-043 Assert reset mid-stream (async, between edges) -> all outputs 0 immediately, w_ready=0, shadow_full=0.
